eeprom_bus_ctrl: RTL and testbench

Single-master cycle sequencer for one 8Kx8 AT28C64-class parallel EEPROM/ROM socket. Converts a simple req/ack host interface into correctly timed nCE/nOE/nWE strobe sequences, drives the data bus tristate enable, and waits out the device's internal write cycle. It sits between the microcode-programming/readback logic and the ROM symbol, so microcode images can be read back and rewritten in-system.

---
 rtl/eeprom_bus_pkg.sv | 27 ++
 rtl/eeprom_wait_timer.sv | 20 ++
 rtl/eeprom_bus_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_eeprom_bus_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_bus_pkg.sv
// Shared types and default timing for the AT28C64-class EEPROM cycle sequencer.
package eeprom_bus_pkg;
  localparam int ADDR_W        = 13;
  localparam int DATA_W        = 8;
  localparam int RD_WAIT_DEF   = 3;
  localparam int WE_PULSE_DEF  = 2;
  localparam int WC_CYCLES_DEF = 10000;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    WR_WAIT,
    WR_POLL,
    WR_GAP
  } busState_e;

  function automatic int cntWidth(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/eeprom_wait_timer.sv
// Loadable down-counter shared by all timed phases of the EEPROM sequencer.
module eeprom_wait_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] loadVal,
  output logic [W-1:0] value,
  output logic         zero
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       value <= '0;
    else if (load) value <= loadVal;
    else if (dec)  value <= value - W'(1);
  end

  assign zero = (value == '0);
endmodule

// File: rtl/eeprom_bus_ctrl.sv
// Req/ack host port to nCE/nOE/nWE strobe sequencer for one parallel EEPROM socket.
// Define EEPROM_DATA_POLL_EN to replace the fixed write-cycle wait with DATA polling.
import eeprom_bus_pkg::*;

module eeprom_bus_ctrl #(
  parameter int RD_WAIT   = RD_WAIT_DEF,
  parameter int WE_PULSE  = WE_PULSE_DEF,
  parameter int WC_CYCLES = WC_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_a,
  output logic [DATA_W-1:0] rom_d_out,
  output logic              rom_d_oe,
  input  logic [DATA_W-1:0] rom_d_in,
  output logic              rom_nce,
  output logic              rom_noe,
  output logic              rom_nwe
);
  localparam int CNT_W = cntWidth(RD_WAIT, WE_PULSE, WC_CYCLES);

  busState_e        state;
  logic             tLoad;
  logic             tDec;
  logic [CNT_W-1:0] tLoadVal;
  logic [CNT_W-1:0] tValue;
  logic             tZero;
`ifdef EEPROM_DATA_POLL_EN
  logic [CNT_W-1:0] pollCnt;
`endif

  // One timer covers the read strobe, the nWE pulse and the write-cycle budget.
  always_comb begin
    tLoad    = 1'b0;
    tDec     = 1'b0;
    tLoadVal = '0;
    case (state)
      IDLE: begin
        tLoad    = req;
        tLoadVal = CNT_W'(RD_WAIT - 1);
      end
      WR_SETUP: begin
        tLoad    = 1'b1;
        tLoadVal = CNT_W'(WE_PULSE - 1);
      end
      WR_HOLD: begin
        tLoad    = 1'b1;
        tLoadVal = CNT_W'(WC_CYCLES - 1);
      end
      default: tDec = (tValue != '0);
    endcase
  end

  eeprom_wait_timer #(.W(CNT_W)) uTimer (
    .clk     (clk),
    .rst     (rst),
    .load    (tLoad),
    .dec     (tDec),
    .loadVal (tLoadVal),
    .value   (tValue),
    .zero    (tZero)
  );

  // Write data is a pure datapath latch; it only matters while rom_d_oe is high.
  always_ff @(posedge clk) begin
    if (state == IDLE && req && we) rom_d_out <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rdata    <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      rom_a    <= '0;
      rom_d_oe <= 1'b0;
      rom_nce  <= 1'b1;
      rom_noe  <= 1'b1;
      rom_nwe  <= 1'b1;
`ifdef EEPROM_DATA_POLL_EN
      pollCnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (req) begin
            busy    <= 1'b1;
            rom_a   <= addr;
            rom_nce <= 1'b0;
            if (we) begin
              rom_d_oe <= 1'b1;
              state    <= WR_SETUP;
            end else begin
              rom_noe <= 1'b0;
              state   <= RD;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RD: begin
          if (tZero) begin
            rdata   <= rom_d_in;
            rom_nce <= 1'b1;
            rom_noe <= 1'b1;
            ack     <= 1'b1;
            state   <= IDLE;
          end
        end
        WR_SETUP: begin
          rom_nwe <= 1'b0;
          state   <= WR_PULSE;
        end
        WR_PULSE: begin
          if (tZero) begin
            rom_nwe <= 1'b1;
            state   <= WR_HOLD;
          end
        end
        WR_HOLD: begin
          rom_d_oe <= 1'b0;
`ifdef EEPROM_DATA_POLL_EN
          rom_noe  <= 1'b0;
          pollCnt  <= CNT_W'(RD_WAIT - 1);
          state    <= WR_POLL;
`else
          rom_nce  <= 1'b1;
          state    <= WR_WAIT;
`endif
        end
        WR_WAIT: begin
          if (tZero) begin
            ack   <= 1'b1;
            err   <= 1'b0;
            state <= IDLE;
          end
        end
`ifdef EEPROM_DATA_POLL_EN
        // A match on the final poll edge wins over a simultaneous timeout.
        WR_POLL: begin
          if (pollCnt == '0) begin
            rom_nce <= 1'b1;
            rom_noe <= 1'b1;
            if (rom_d_in[7] == rom_d_out[7]) begin
              ack   <= 1'b1;
              err   <= 1'b0;
              state <= IDLE;
            end else if (tZero) begin
              ack   <= 1'b1;
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              state <= WR_GAP;
            end
          end else begin
            pollCnt <= pollCnt - CNT_W'(1);
            if (tZero) begin
              rom_nce <= 1'b1;
              rom_noe <= 1'b1;
              ack     <= 1'b1;
              err     <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        WR_GAP: begin
          if (tZero) begin
            ack   <= 1'b1;
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            rom_nce <= 1'b0;
            rom_noe <= 1'b0;
            pollCnt <= CNT_W'(RD_WAIT - 1);
            state   <= WR_POLL;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eeprom_bus_ctrl.sv
// Bench for eeprom_bus_ctrl: behavioural EEPROM device, table vectors, corner sequences, random traffic.
module tb_eeprom_bus_ctrl;
  localparam int RDW = 3;
  localparam int WEP = 2;
`ifdef EEPROM_DATA_POLL_EN
  localparam int WC   = 50;
  localparam int WLAT = WEP + 2 + RDW;
`else
  localparam int WC   = 20;
  localparam int WLAT = WEP + 2 + WC;
`endif
  localparam int RLAT = RDW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [12:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        ack, err, busy;
  logic [12:0] rom_a;
  logic [7:0]  rom_d_out;
  logic        rom_d_oe;
  logic [7:0]  romDin;
  logic        rom_nce, rom_noe, rom_nwe;

  eeprom_bus_ctrl #(.RD_WAIT(RDW), .WE_PULSE(WEP), .WC_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy), .rom_a(rom_a),
    .rom_d_out(rom_d_out), .rom_d_oe(rom_d_oe), .rom_d_in(romDin),
    .rom_nce(rom_nce), .rom_noe(rom_noe), .rom_nwe(rom_nwe)
  );

  always #5 clk = ~clk;

  // Device model: byte array, write committed on nWE rising, DATA-poll emulation during writes.
  logic [7:0] mem    [0:8191];
  logic [7:0] refMem [0:8191];
  logic [7:0] curW = '0;
  logic       inWrite = 1'b0;
  int         failN = 0;
  int         pollBase = 0;
  int         pollFalls = 0;

  assign romDin = (rom_nce || rom_noe) ? 8'h00 :
                  (inWrite && (pollFalls - pollBase) <= failN) ? {~curW[7], curW[6:0]} :
                  mem[rom_a];

  always @(posedge rom_nwe) if (!rst && !rom_nce) mem[rom_a] = rom_d_out;
  always @(negedge rom_noe) pollFalls++;

  int         total = 0;
  int         bad = 0;
  int         noeLowCnt = 0, nweLowCnt = 0, nweBadCnt = 0, viol = 0;
  logic       prevNce = 1'b1;
  logic [12:0] prevA = '0;

  always @(negedge clk) begin
    if (!rom_noe) noeLowCnt++;
    if (!rom_nwe) begin
      nweLowCnt++;
      if (!rom_d_oe || rom_d_out !== curW) nweBadCnt++;
    end
    if (!rom_nwe && !rom_noe) viol++;
    if (rom_d_oe && !rom_noe) viol++;
    if (!rom_nce && !prevNce && rom_a !== prevA) viol++;
    prevNce = rom_nce;
    prevA   = rom_a;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic doTxn(input logic w, input logic [12:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd, output logic er,
                       output int noeD, output int nweD, output int nweBadD, output int pollD);
    int n0, w0, b0, p0;
    bit got;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    curW = w ? d : curW;
    inWrite = w;
    pollBase = pollFalls;
    n0 = noeLowCnt; w0 = nweLowCnt; b0 = nweBadCnt; p0 = pollFalls;
    @(posedge clk); #1;
    req = 1'b0;
    chk("busyAtAccept", busy, 1);
    lat = 0; got = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(posedge clk); lat++; #1;
      if (ack) got = 1;
    end
    chk("ackSeen", got, 1);
    rd = rdata; er = err;
    noeD = noeLowCnt - n0; nweD = nweLowCnt - w0; nweBadD = nweBadCnt - b0; pollD = pollFalls - p0;
    inWrite = 1'b0;
    @(posedge clk); #1;
    chk("ackOnePulse", ack, 0);
    chk("busyDropped", busy, 0);
  endtask

  typedef struct {
    logic        w;
    logic [12:0] a;
    logic [7:0]  d;
    logic [7:0]  expRd;
    int          expLat;
  } vec_t;

  vec_t tbl [8];
  logic [12:0] pool [8];

  initial begin
    int lat, noeD, nweD, nweBadD, pollD, ackSeen;
    logic [7:0] rd, lastRd;
    logic er;
    logic [12:0] ra;
    logic [7:0] rdv;
    logic rw;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rstNce", rom_nce, 1);
    chk("rstNoe", rom_noe, 1);
    chk("rstNwe", rom_nwe, 1);
    chk("rstDoe", rom_d_oe, 0);
    chk("rstAck", ack, 0);
    chk("rstErr", err, 0);
    chk("rstBusy", busy, 0);
    chk("rstRdata", rdata, 0);
    chk("rstRomA", rom_a, 0);

    for (int i = 0; i < 8192; i++) begin
      mem[i] = 8'($urandom);
      refMem[i] = mem[i];
    end
    mem[13'h1ABC] = 8'h5A; refMem[13'h1ABC] = 8'h5A;
    mem[13'h0000] = 8'h3E; refMem[13'h0000] = 8'h3E;
    @(negedge clk); rst = 1'b0;

    // Table-driven vectors; expectations predicted here from the reference memory.
    tbl[0] = '{1'b1, 13'h0010, 8'hA5, 8'h00, WLAT};
    tbl[1] = '{1'b0, 13'h0010, 8'h00, 8'h00, RLAT};
    tbl[2] = '{1'b0, 13'h1ABC, 8'h00, 8'h00, RLAT};
    tbl[3] = '{1'b1, 13'h1FFF, 8'h00, 8'h00, WLAT};
    tbl[4] = '{1'b0, 13'h1FFF, 8'h00, 8'h00, RLAT};
    tbl[5] = '{1'b0, 13'h0000, 8'h00, 8'h00, RLAT};
    tbl[6] = '{1'b1, 13'h0000, 8'hFF, 8'h00, WLAT};
    tbl[7] = '{1'b0, 13'h0000, 8'h00, 8'h00, RLAT};
    lastRd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].w) refMem[tbl[i].a] = tbl[i].d;
      else lastRd = refMem[tbl[i].a];
      tbl[i].expRd = lastRd;
    end
    for (int i = 0; i < 8; i++) begin
      doTxn(tbl[i].w, tbl[i].a, tbl[i].d, lat, rd, er, noeD, nweD, nweBadD, pollD);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].expLat);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].expRd);
      chk($sformatf("tbl%0d_err", i), er, 0);
      if (tbl[i].w) begin
        chk($sformatf("tbl%0d_nweLow", i), nweD, WEP);
        chk($sformatf("tbl%0d_nweData", i), nweBadD, 0);
      end else begin
        chk($sformatf("tbl%0d_noeLow", i), noeD, RDW);
      end
    end

    // req held high: read then write accepted in the read's ack cycle
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 13'h0010;
    @(posedge clk); #1;
    we = 1'b1; addr = 13'h0200; wdata = 8'h3C;
    ackSeen = 0;
    for (int i = 0; i < 100 && ackSeen == 0; i++) begin
      @(negedge clk);
      if (ack) ackSeen = 1;
    end
    chk("b2bReadAck", ackSeen, 1);
    chk("b2bRdata", rdata, refMem[13'h0010]);
    chk("b2bNceHighInAck", rom_nce, 1);
    curW = 8'h3C; inWrite = 1'b1; pollBase = pollFalls;
    @(posedge clk); #1;
    req = 1'b0;
    chk("b2bWrAccepted", busy, 1);
    chk("b2bWrSetupNce", rom_nce, 0);
    chk("b2bWrSetupDoe", rom_d_oe, 1);
    lat = 0; ackSeen = 0;
    for (int i = 0; i < 500 && ackSeen == 0; i++) begin
      @(posedge clk); lat++; #1;
      if (ack) ackSeen = 1;
    end
    inWrite = 1'b0;
    chk("b2bWrAck", ackSeen, 1);
    chk("b2bWrLat", lat, WLAT);
    refMem[13'h0200] = 8'h3C;
    lastRd = refMem[13'h0010];
    doTxn(1'b0, 13'h0200, 8'h00, lat, rd, er, noeD, nweD, nweBadD, pollD);
    chk("b2bReadBack", rd, 8'h3C);
    lastRd = rd;

`ifdef EEPROM_DATA_POLL_EN
    failN = 5;
    doTxn(1'b1, 13'h0300, 8'h81, lat, rd, er, noeD, nweD, nweBadD, pollD);
    chk("pollCount", pollD, 6);
    chk("pollErr", er, 0);
    chk("pollLat", lat, WEP + 2 + 6 * RDW + 5);
    chk("pollRdataKept", rd, lastRd);
    refMem[13'h0300] = 8'h81;
    failN = 100000;
    doTxn(1'b1, 13'h0301, 8'h12, lat, rd, er, noeD, nweD, nweBadD, pollD);
    chk("timeoutErr", er, 1);
    chk("timeoutLat", lat, WEP + 2 + WC);
    refMem[13'h0301] = 8'h12;
    failN = 0;
`endif

    // Asynchronous reset during the nWE pulse
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 13'h0400; wdata = 8'h77;
    curW = 8'h77; inWrite = 1'b1; pollBase = pollFalls;
    @(posedge clk); #1;
    req = 1'b0;
    ackSeen = 0;
    for (int i = 0; i < 20 && ackSeen == 0; i++) begin
      @(posedge clk); #1;
      if (!rom_nwe) ackSeen = 1;
    end
    chk("rstMidReachedPulse", ackSeen, 1);
    #2 rst = 1'b1;
    #1;
    chk("asyncRstNwe", rom_nwe, 1);
    chk("asyncRstNce", rom_nce, 1);
    chk("asyncRstNoe", rom_noe, 1);
    chk("asyncRstDoe", rom_d_oe, 0);
    chk("asyncRstBusy", busy, 0);
    chk("asyncRstRdata", rdata, 0);
    inWrite = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ackSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ack) ackSeen = 1;
    end
    chk("noAckAfterRst", ackSeen, 0);
    doTxn(1'b0, 13'h1ABC, 8'h00, lat, rd, er, noeD, nweD, nweBadD, pollD);
    chk("postRstRead", rd, 8'h5A);
    chk("postRstLat", lat, RLAT);
    lastRd = rd;

    // Randomized traffic against the reference memory
    pool[0] = 13'h0000; pool[1] = 13'h0001; pool[2] = 13'h0010; pool[3] = 13'h1ABC;
    pool[4] = 13'h1FFF; pool[5] = 13'h0AAA; pool[6] = 13'h1555; pool[7] = 13'h0200;
    for (int i = 0; i < 30; i++) begin
      ra  = pool[$urandom_range(0, 7)];
      rw  = 1'($urandom);
      rdv = 8'($urandom);
      doTxn(rw, ra, rdv, lat, rd, er, noeD, nweD, nweBadD, pollD);
      if (rw) begin
        refMem[ra] = rdv;
        chk($sformatf("rnd%0d_wrLat", i), lat, WLAT);
        chk($sformatf("rnd%0d_wrNwe", i), nweD, WEP);
      end else begin
        lastRd = refMem[ra];
        chk($sformatf("rnd%0d_rdLat", i), lat, RLAT);
      end
      chk($sformatf("rnd%0d_rdata", i), rd, lastRd);
      chk($sformatf("rnd%0d_err", i), er, 0);
    end

    chk("strobeInvariants", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
